// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC and issues one request at a time to a
// variable-latency instruction memory. The returned word is registered and
// presented to the decoder with a valid flag. Jump, taken-branch and flush
// redirects are applied here.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_valid,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  output logic [31:0]       ins,
  output logic              ins_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);

  logic [1:0]        state, state_d;
  // run is clear for the first cycle out of reset so imem_req stays low
  // while reset is applied and the first request appears one cycle later.
  logic              run;
  // kill marks the single outstanding response as stale after a redirect.
  logic              kill, kill_d;
  logic [ADDR_W-1:0] pc_d;
  logic [31:0]       ins_d;
  logic              ins_valid_d;

  assign imem_req  = (state == FETCH) && run;
  assign imem_addr = pc & ALIGN_MASK;
  assign pc_plus4  = pc + PC_STEP;

  // Next-state, PC redirect and response capture; flush outranks everything.
  always_comb begin
    state_d     = state;
    kill_d      = kill;
    pc_d        = pc;
    ins_d       = ins;
    ins_valid_d = ins_valid;
    case (state)
      FETCH: begin
        ins_valid_d = 1'b0;
        if (!run) begin
          // No request goes out in this cycle, so a flush only moves the PC.
          if (flush) pc_d = flush_pc & ALIGN_MASK;
        end else begin
          state_d = WAIT;
          if (flush) begin
            pc_d   = flush_pc & ALIGN_MASK;
            kill_d = 1'b1;
          end
        end
      end
      WAIT: begin
        if (imem_valid) begin
          if (kill || flush) begin
            kill_d  = 1'b0;
            state_d = FETCH;
            if (flush) pc_d = flush_pc & ALIGN_MASK;
          end else begin
            ins_d       = imem_rdata;
            ins_valid_d = 1'b1;
            state_d     = HOLD;
          end
        end else if (flush) begin
          pc_d   = flush_pc & ALIGN_MASK;
          kill_d = 1'b1;
        end
      end
      HOLD: begin
        if (flush) begin
          pc_d        = flush_pc & ALIGN_MASK;
          ins_valid_d = 1'b0;
          state_d     = FETCH;
        end else if (!stall) begin
          if (jump)              pc_d = jump_target & ALIGN_MASK;
          else if (branch_taken) pc_d = branch_target & ALIGN_MASK;
          else                   pc_d = pc_plus4;
          ins_valid_d = 1'b0;
          state_d     = FETCH;
        end
      end
      default: begin
        state_d     = FETCH;
        kill_d      = 1'b0;
        ins_valid_d = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      run       <= 1'b0;
      kill      <= 1'b0;
      pc        <= RESET_PC;
      ins       <= '0;
      ins_valid <= 1'b0;
    end else begin
      state     <= state_d;
      run       <= 1'b1;
      kill      <= kill_d;
      pc        <= pc_d;
      ins       <= ins_d;
      ins_valid <= ins_valid_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a directed vector table for the basic fetch,
// stall and redirect-priority sequence, hand-written multi-cycle corner
// sequences, and randomized traffic against a transaction-level model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = '0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic [31:0] ins;
  logic        ins_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .stall(stall), .jump(jump), .jump_target(jump_target),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .flush(flush), .flush_pc(flush_pc),
    .ins(ins), .ins_valid(ins_valid), .pc(pc), .pc_plus4(pc_plus4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        v;  logic [31:0] rd;
    logic        st; logic        j;  logic [31:0] jt;
    logic        br; logic [31:0] bt;
    logic        e_req; logic [31:0] e_addr;
    logic        e_iv;  logic [31:0] e_ins; logic [31:0] e_pc;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [31:0] rd, input logic st,
                              input logic j, input logic [31:0] jt, input logic br,
                              input logic [31:0] bt, input logic e_req,
                              input logic [31:0] e_addr, input logic e_iv,
                              input logic [31:0] e_ins, input logic [31:0] e_pc);
    vec_t r;
    r.v = v; r.rd = rd; r.st = st; r.j = j; r.jt = jt; r.br = br; r.bt = bt;
    r.e_req = e_req; r.e_addr = e_addr; r.e_iv = e_iv; r.e_ins = e_ins; r.e_pc = e_pc;
    return r;
  endfunction

  // ---------------- reference model ----------------
  bit          m_live, m_pend, m_stale, m_valid;
  logic [31:0] m_pc, m_ins;
  int          lat = 1;
  int          mem_cnt = 0;
  logic [31:0] mem_word = '0;
  bit          saw_req;
  logic [31:0] last_addr;

  function automatic logic [31:0] al(input logic [31:0] x);
    return x & 32'hFFFF_FFFC;
  endfunction

  // One clock edge of the fetch rules seen as transactions: an outstanding
  // request, whether its answer is stale, and the held instruction.
  task automatic model_step(input bit f, input logic [31:0] fp, input bit st,
                            input bit j, input logic [31:0] jt, input bit b,
                            input logic [31:0] bt, input bit v, input logic [31:0] rd);
    if (!m_live) begin
      m_live = 1;
      if (f) m_pc = al(fp);
    end else if (m_pend) begin
      if (v) begin
        m_pend = 0;
        if (f) m_pc = al(fp);
        if (!(f || m_stale)) begin m_ins = rd; m_valid = 1; end
        m_stale = 0;
      end else if (f) begin
        m_pc = al(fp); m_stale = 1;
      end
    end else if (!m_valid) begin
      m_pend = 1;
      if (f) begin m_pc = al(fp); m_stale = 1; end
    end else begin
      if (f) begin
        m_pc = al(fp); m_valid = 0;
      end else if (!st) begin
        m_pc = j ? al(jt) : (b ? al(bt) : m_pc + 32'd4);
        m_valid = 0;
      end
    end
  endtask

  task automatic drive(input bit f, input logic [31:0] fp, input bit st, input bit j,
                       input logic [31:0] jt, input bit b, input logic [31:0] bt,
                       input bit v, input logic [31:0] rd);
    flush = f; flush_pc = fp; stall = st; jump = j; jump_target = jt;
    branch_taken = b; branch_target = bt; imem_valid = v; imem_rdata = rd;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, '0, 0, 0, '0, 0, '0, 0, '0);
    #1;
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_ins_valid", ins_valid, 1'b0);
    chk("rst_ins", ins, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc_plus4", pc_plus4, 32'h4);
    repeat (2) @(negedge clk);
    m_live = 0; m_pend = 0; m_stale = 0; m_valid = 0; m_pc = 32'h0; m_ins = '0;
    mem_cnt = 0;
    rst_n = 1'b1;
    model_step(0, '0, 0, 0, '0, 0, '0, 0, '0);
  endtask

  // Compare outputs against the model, run the memory, then apply inputs.
  task automatic tick(input bit f, input logic [31:0] fp, input bit st, input bit j,
                      input logic [31:0] jt, input bit b, input logic [31:0] bt,
                      input bit stray);
    bit          v;
    bit          e_req;
    logic [31:0] rd;
    @(negedge clk);
    e_req = m_live && !m_pend && !m_valid;
    chk("imem_req", imem_req, e_req);
    if (e_req) chk("imem_addr", imem_addr, m_pc);
    chk("ins_valid", ins_valid, m_valid);
    if (m_valid) chk("ins", ins, m_ins);
    chk("pc", pc, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    saw_req = imem_req;
    last_addr = imem_addr;
    v = 0;
    rd = $urandom;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin v = 1; rd = mem_word; end
    end
    if (stray) v = 1;
    if (imem_req) begin mem_cnt = lat; mem_word = $urandom; end
    drive(f, fp, st, j, jt, b, bt, v, rd);
    model_step(f, fp, st, j, jt, b, bt, v, rd);
  endtask

  task automatic idle(input bit st);
    tick(0, '0, st, 0, '0, 0, '0, 0);
  endtask

  task automatic until_req(input string name);
    int n = 0;
    do begin idle(0); n++; end while (!saw_req && n < 30);
    chk(name, saw_req, 1'b1);
  endtask

  task automatic until_valid(input string name);
    int n = 0;
    do begin idle(1); n++; end while (!ins_valid && n < 30);
    chk(name, ins_valid, 1'b1);
  endtask

  vec_t tbl[22];

  initial begin
    //            v  rd            st j  jt       br bt       req addr    iv ins           pc
    tbl[0]  = mk(0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   1, 32'h0,   0, 32'h0,        32'h0);
    tbl[1]  = mk(1, 32'h8C01_0004,0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h0,        32'h0);
    tbl[2]  = mk(0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h8C01_0004,32'h0);
    tbl[3]  = mk(0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   1, 32'h4,   0, 32'h0,        32'h4);
    tbl[4]  = mk(1, 32'h8C02_0008,0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h0,        32'h4);
    for (int unsigned i = 5; i < 10; i++)
      tbl[i] = mk(0, 32'h0,       1, 1, 32'h100, 0, 32'h0,   0, 32'h0,   1, 32'h8C02_0008,32'h4);
    tbl[10] = mk(0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h8C02_0008,32'h4);
    tbl[11] = mk(0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   1, 32'h8,   0, 32'h0,        32'h8);
    tbl[12] = mk(1, 32'h0000_0013,0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h0,        32'h8);
    tbl[13] = mk(0, 32'h0,        0, 1, 32'h100, 1, 32'h200, 0, 32'h0,   1, 32'h0000_0013,32'h8);
    tbl[14] = mk(0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   1, 32'h100, 0, 32'h0,        32'h100);
    tbl[15] = mk(1, 32'h0000_0063,0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h0,        32'h100);
    tbl[16] = mk(0, 32'h0,        0, 0, 32'h0,   1, 32'h200, 0, 32'h0,   1, 32'h0000_0063,32'h100);
    tbl[17] = mk(0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   1, 32'h200, 0, 32'h0,        32'h200);
    tbl[18] = mk(1, 32'h0000_0067,0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h0,        32'h200);
    tbl[19] = mk(0, 32'h0,        0, 0, 32'h0,   1, 32'h203, 0, 32'h0,   1, 32'h0000_0067,32'h200);
    tbl[20] = mk(0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   1, 32'h200, 0, 32'h0,        32'h200);
    tbl[21] = mk(1, 32'h1111_2222,0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h0,        32'h200);

    do_reset();
    for (int unsigned i = 0; i < 22; i++) begin
      @(negedge clk);
      chk($sformatf("tbl%0d_req", i), imem_req, tbl[i].e_req);
      if (tbl[i].e_req) chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_ins_valid", i), ins_valid, tbl[i].e_iv);
      if (tbl[i].e_iv) chk($sformatf("tbl%0d_ins", i), ins, tbl[i].e_ins);
      chk($sformatf("tbl%0d_pc", i), pc, tbl[i].e_pc);
      chk($sformatf("tbl%0d_pc_plus4", i), pc_plus4, tbl[i].e_pc + 32'd4);
      drive(0, '0, tbl[i].st, tbl[i].j, tbl[i].jt, tbl[i].br, tbl[i].bt, tbl[i].v, tbl[i].rd);
    end

    // Latency 4, flush two cycles after the request.
    do_reset();
    lat = 4;
    idle(0);
    chk("lat4_first_req", saw_req, 1'b1);
    chk("lat4_first_addr", last_addr, 32'h0);
    idle(0);
    tick(1, 32'h80, 0, 0, '0, 0, '0, 0);
    until_req("lat4_refetch_timeout");
    chk("lat4_refetch_addr", last_addr, 32'h80);
    repeat (5) idle(1);
    chk("lat4_valid_after_refetch", ins_valid, 1'b1);
    chk("lat4_ins", ins, mem_word);
    chk("lat4_pc", pc, 32'h80);

    // Flush in the same cycle as the response.
    lat = 2;
    until_req("coinc_req_timeout");
    idle(0);
    tick(1, 32'h146, 0, 0, '0, 0, '0, 0);
    idle(0);
    chk("coinc_refetch", saw_req, 1'b1);
    chk("coinc_addr", last_addr, 32'h144);

    // Sequential wrap from the top of the address space.
    until_valid("wrap_valid1_timeout");
    tick(0, '0, 0, 1, 32'hFFFF_FFFE, 0, '0, 0);
    until_req("wrap_req_top_timeout");
    chk("wrap_addr_top", last_addr, 32'hFFFF_FFFC);
    until_valid("wrap_valid2_timeout");
    chk("wrap_pc_top", pc, 32'hFFFF_FFFC);
    chk("wrap_pc_plus4", pc_plus4, 32'h0);
    idle(0);
    until_req("wrap_req0_timeout");
    chk("wrap_addr0", last_addr, 32'h0);

    // Stray responses in HOLD and FETCH are ignored.
    until_valid("stray_valid_timeout");
    tick(0, '0, 1, 0, '0, 0, '0, 1);
    tick(0, '0, 1, 0, '0, 0, '0, 1);
    idle(0);
    tick(0, '0, 0, 0, '0, 0, '0, 1);
    chk("stray_fetch_req", saw_req, 1'b1);
    until_valid("stray_resp_timeout");
    chk("stray_real_word", ins, mem_word);

    // Asynchronous reset while waiting on a response.
    lat = 4;
    idle(0);
    until_req("rstwait_req_timeout");
    idle(0);
    #2;
    do_reset();
    until_req("rstwait_restart_timeout");
    chk("rstwait_restart_addr", last_addr, 32'h0);

    // Randomized traffic against the model.
    do_reset();
    for (int unsigned n = 0; n < 600; n++) begin
      bit          f, st, j, b, s;
      logic [31:0] fp, jt, bt;
      lat = int'($urandom_range(1, 4));
      f  = ($urandom_range(0, 19) == 0);
      st = ($urandom_range(0, 1) == 1);
      j  = ($urandom_range(0, 3) == 0);
      b  = ($urandom_range(0, 3) == 0);
      fp = $urandom; jt = $urandom; bt = $urandom;
      s  = (!m_pend && mem_cnt == 0 && $urandom_range(0, 9) == 0);
      tick(f, fp, st, j, jt, b, bt, s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
